// File: rtl/mm_arbiter_if.sv
// rtl/mm_arbiter_if.sv - cache-side and main-memory-side signal bundle for mm_arbiter
interface mm_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              re_i;
   logic [ADDR_W-1:0] addr_i;
   logic              valid_i;
   logic              re_d;
   logic [ADDR_W-1:0] addr_d;
   logic              valid_d;
   logic [DATA_W-1:0] rdata;
   logic              mm_re;
   logic [ADDR_W-1:0] mm_addr;
   logic [DATA_W-1:0] mm_rdata;
   logic              mm_valid;
   logic              mm_reset;
   logic              busy;
   logic              owner;

   modport slave (
      input  re_i, addr_i, re_d, addr_d, mm_rdata, mm_valid,
      output valid_i, valid_d, rdata, mm_re, mm_addr, mm_reset, busy, owner
   );

   modport master (
      output re_i, addr_i, re_d, addr_d, mm_rdata, mm_valid,
      input  valid_i, valid_d, rdata, mm_re, mm_addr, mm_reset, busy, owner
   );
endinterface

// File: rtl/mm_arbiter.sv
// rtl/mm_arbiter.sv - round-robin arbiter sharing the main-memory read port between I and D caches
module mm_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input logic          clk,
   input logic          reset,
   mm_arbiter_if.slave  bus
);
   localparam int BEAT_W = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {IDLE, START, BURST, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [BEAT_W-1:0] beat;
   logic              last;
   logic              owner_q;
   logic              mm_re_q;
   logic              mm_reset_q;
   logic              busy_q;

   logic owner_re;
   logic grant_d;
   logic accept;
   logic last_beat;

   // On a tie the side that was not served last wins.
   assign grant_d   = bus.re_d && (!bus.re_i || !last);
   assign owner_re  = owner_q ? bus.re_d : bus.re_i;
   assign accept    = (state == BURST) && owner_re && bus.mm_valid;
   assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         base       <= '0;
         beat       <= '0;
         last       <= 1'b1;
         owner_q    <= 1'b0;
         mm_re_q    <= 1'b0;
         mm_reset_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.re_i || bus.re_d) begin
                  owner_q    <= grant_d;
                  base       <= grant_d ? bus.addr_d : bus.addr_i;
                  beat       <= '0;
                  busy_q     <= 1'b1;
                  mm_reset_q <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               mm_reset_q <= 1'b0;
               mm_re_q    <= 1'b1;
               state      <= BURST;
            end
            BURST: begin
               // A dropped request aborts the burst; the owner gets no strobe that cycle.
               if (!owner_re) begin
                  beat       <= '0;
                  mm_re_q    <= 1'b0;
                  mm_reset_q <= 1'b1;
                  state      <= DONE;
               end else if (bus.mm_valid) begin
                  beat <= beat + BEAT_W'(1);
                  if (last_beat) begin
                     mm_re_q    <= 1'b0;
                     mm_reset_q <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               last       <= owner_q;
               mm_reset_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mm_addr  = (state == BURST) ? base + ADDR_W'(beat) : base;
   assign bus.mm_re    = mm_re_q;
   assign bus.mm_reset = mm_reset_q;
   assign bus.busy     = busy_q;
   assign bus.owner    = owner_q;
   assign bus.valid_i  = accept && !owner_q;
   assign bus.valid_d  = accept && owner_q;
   assign bus.rdata    = bus.mm_rdata;
endmodule

// File: tb/tb_mm_arbiter.sv
// tb/tb_mm_arbiter.sv - randomized and directed self-checking bench for mm_arbiter
module tb_mm_arbiter;
   localparam int LW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   mm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mm_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Grant-level model: one record per grant, aged by cycles since the grant edge.
   bit          g_active = 1'b0;
   bit          g_owner  = 1'b0;
   bit          g_end    = 1'b0;
   bit          m_last   = 1'b1;
   int          g_age    = 0;
   int          g_n      = 0;
   logic [31:0] g_base   = '0;
   int          given [2] = '{0, 0};
   int          start_cnt [2] = '{0, 0};

   bit          pat [7] = '{1, 0, 0, 1, 0, 1, 1};
   logic [31:0] ea  [7] = '{32'h3FE, 32'h3FF, 32'h3FF, 32'h3FF, 32'h400, 32'h400, 32'h401};
   int          pulses;

   function automatic bit in_start();
      return g_active && (g_age == 0);
   endfunction

   function automatic bit in_done();
      return g_active && g_end;
   endfunction

   function automatic bit in_burst();
      return g_active && (g_age > 0) && !g_end;
   endfunction

   function automatic bit pick(input bit ri, input bit rd, input bit lst);
      return (ri && rd) ? !lst : rd;
   endfunction

   function automatic bit exp_valid(input bit s);
      return in_burst() && (g_owner == s) && bus.mm_valid && (s ? bus.re_d : bus.re_i);
   endfunction

   function automatic logic [31:0] exp_addr();
      return in_burst() ? g_base + 32'(g_n) : g_base;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         g_active <= 1'b0;
         g_owner  <= 1'b0;
         g_end    <= 1'b0;
         m_last   <= 1'b1;
         g_age    <= 0;
         g_n      <= 0;
         g_base   <= '0;
      end else if (!g_active) begin
         if (bus.re_i || bus.re_d) begin
            g_active <= 1'b1;
            g_owner  <= pick(bus.re_i, bus.re_d, m_last);
            g_base   <= pick(bus.re_i, bus.re_d, m_last) ? bus.addr_d : bus.addr_i;
            g_age    <= 0;
            g_n      <= 0;
            g_end    <= 1'b0;
         end
      end else if (g_end) begin
         m_last   <= g_owner;
         g_active <= 1'b0;
      end else if (g_age == 0) begin
         g_age <= 1;
      end else if (!(g_owner ? bus.re_d : bus.re_i)) begin
         g_end <= 1'b1;
      end else if (bus.mm_valid) begin
         given[g_owner] <= given[g_owner] + 1;
         g_n            <= g_n + 1;
         if (g_n + 1 == LW) g_end <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy",     64'(bus.busy),     64'(g_active));
      chk("owner",    64'(bus.owner),    64'(g_owner));
      chk("mm_re",    64'(bus.mm_re),    64'(in_burst()));
      chk("mm_reset", 64'(bus.mm_reset), 64'(in_start() || in_done()));
      chk("mm_addr",  64'(bus.mm_addr),  64'(exp_addr()));
      chk("valid_i",  64'(bus.valid_i),  64'(exp_valid(1'b0)));
      chk("valid_d",  64'(bus.valid_d),  64'(exp_valid(1'b1)));
      chk("rdata",    64'(bus.rdata),    64'(bus.mm_rdata));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic agent_step(input bit s);
      logic        cur;
      logic [31:0] a;
      cur = s ? bus.re_d : bus.re_i;
      a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      if (!cur) begin
         if ($urandom_range(0, 3) == 0) begin
            start_cnt[s] = given[s];
            if (s) begin bus.re_d = 1'b1; bus.addr_d = a; end
            else   begin bus.re_i = 1'b1; bus.addr_i = a; end
         end
      end else if ((given[s] - start_cnt[s] >= LW) ||
                   (in_burst() && g_owner == s && $urandom_range(0, 15) == 0)) begin
         if (s) bus.re_d = 1'b0;
         else   bus.re_i = 1'b0;
      end
   endtask

   initial begin
      bus.re_i = 0; bus.addr_i = '0; bus.re_d = 0; bus.addr_d = '0;
      bus.mm_valid = 0; bus.mm_rdata = '0;
      #2;
      chk("rst_busy",  64'(bus.busy),    64'd0);
      chk("rst_addr",  64'(bus.mm_addr), 64'd0);
      chk("rst_owner", 64'(bus.owner),   64'd0);
      chk("rst_mm_re", 64'(bus.mm_re),   64'd0);
      step(); step();
      reset = 1'b1;

      // Single I burst with memory always ready
      step();
      bus.re_i = 1; bus.addr_i = 32'h100; bus.mm_valid = 1; bus.mm_rdata = 32'hA5A5_0001;
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 6) bus.re_i = 0;
         bus.mm_rdata = $urandom;
         #2;
         if (c == 1) begin
            chk("t1_start_mm_reset", 64'(bus.mm_reset), 64'd1);
            chk("t1_start_mm_re",    64'(bus.mm_re),    64'd0);
            chk("t1_start_busy",     64'(bus.busy),     64'd1);
            chk("t1_start_valid_i",  64'(bus.valid_i),  64'd0);
         end else if (c <= 5) begin
            chk("t1_addr",    64'(bus.mm_addr), 64'(32'h100 + c - 2));
            chk("t1_valid_i", 64'(bus.valid_i), 64'd1);
         end else if (c == 6) begin
            chk("t1_done_mm_reset", 64'(bus.mm_reset), 64'd1);
            chk("t1_done_mm_re",    64'(bus.mm_re),    64'd0);
            chk("t1_done_busy",     64'(bus.busy),     64'd1);
         end else begin
            chk("t1_idle_busy", 64'(bus.busy), 64'd0);
         end
         chk("t1_valid_d", 64'(bus.valid_d), 64'd0);
      end

      // Stalled memory on a D burst crossing 0x3FF->0x400, stray valid in IDLE/START
      bus.re_d = 1; bus.addr_d = 32'h3FE; bus.mm_valid = 1;
      #2;
      chk("t2_idle_stray", 64'(bus.valid_d), 64'd0);
      pulses = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         bus.mm_valid = (c >= 2 && c <= 8) ? pat[c-2] : (c == 1);
         if (c == 9) bus.re_d = 0;
         #2;
         if (c >= 2 && c <= 8) begin
            chk("t2_addr",    64'(bus.mm_addr), 64'(ea[c-2]));
            chk("t2_valid_d", 64'(bus.valid_d), 64'(pat[c-2]));
         end
         if (c == 1) chk("t2_start_stray", 64'(bus.valid_d), 64'd0);
         if (c == 9) chk("t2_done_mm_re",  64'(bus.mm_re),   64'd0);
         if (bus.valid_d) pulses++;
         chk("t2_valid_i", 64'(bus.valid_i), 64'd0);
      end
      chk("t2_pulses",   64'(pulses),   64'd4);
      chk("t2_end_busy", 64'(bus.busy), 64'd0);

      // Abort after the second beat, then a fresh D request restarts at base
      bus.re_d = 1; bus.addr_d = 32'h200; bus.mm_valid = 1;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (c == 4 || c == 12) bus.re_d = 0;
         if (c == 6) bus.re_d = 1;
         #2;
         if (c == 2 || c == 3) chk("t3_valid_d", 64'(bus.valid_d), 64'd1);
         if (c == 4) chk("t3_abort_valid_d", 64'(bus.valid_d), 64'd0);
         if (c == 5) begin
            chk("t3_done_mm_re",    64'(bus.mm_re),    64'd0);
            chk("t3_done_mm_reset", 64'(bus.mm_reset), 64'd1);
            chk("t3_done_valid_d",  64'(bus.valid_d),  64'd0);
         end
         if (c == 6)  chk("t3_idle_busy", 64'(bus.busy), 64'd0);
         if (c == 8)  chk("t3_restart_addr", 64'(bus.mm_addr), 64'h200);
         if (c == 13) chk("t3_end_busy", 64'(bus.busy), 64'd0);
      end

      // Async reset mid-burst, then a tie from reset release
      bus.re_i = 1; bus.addr_i = 32'h300; bus.mm_valid = 1;
      for (int c = 1; c <= 4; c++) step();
      #2;
      reset = 1'b0;
      #1;
      chk("t4_rst_mm_re",    64'(bus.mm_re),    64'd0);
      chk("t4_rst_busy",     64'(bus.busy),     64'd0);
      chk("t4_rst_valid_i",  64'(bus.valid_i),  64'd0);
      chk("t4_rst_mm_addr",  64'(bus.mm_addr),  64'd0);
      chk("t4_rst_mm_reset", 64'(bus.mm_reset), 64'd0);
      bus.re_d = 1; bus.addr_d = 32'h500;
      step();
      reset = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         #2;
         if (c == 1 || c == 8 || c == 15) begin
            chk("t5_start_busy",     64'(bus.busy),     64'd1);
            chk("t5_start_mm_reset", 64'(bus.mm_reset), 64'd1);
            chk("t5_start_owner",    64'(bus.owner),    (c == 8) ? 64'd1 : 64'd0);
         end
         if (c == 2) chk("t5_i_addr", 64'(bus.mm_addr), 64'h300);
         if (c == 7) chk("t5_gap_busy", 64'(bus.busy), 64'd0);
         if (c == 9) chk("t5_d_addr", 64'(bus.mm_addr), 64'h500);
      end
      bus.re_i = 0; bus.re_d = 0;
      for (int c = 0; c < 6; c++) step();

      // Random traffic from two well-behaved requesters
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         bus.mm_valid = ($urandom_range(0, 9) < 7);
         bus.mm_rdata = $urandom;
         agent_step(1'b0);
         agent_step(1'b1);
      end
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Shares the single main-memory read port between the instruction-cache and data-cache controllers. Each cache controller requests a whole cache-line burst. The arbiter grants one requester at a time using round-robin priority. For the granted requester it issues the burst-restart pulse, drives word addresses, counts returned beats and steers the beat-valid strobe back to the owner. It sits between the cache controllers' main-memory side (`re_mm`, `mem_valid_mm`, `reset_mm`) and the main-memory model.

## Interface
Parameters:
- ADDR_W, 32, word-address width
- DATA_W, 32, data word width
- LINE_WORDS, 4, beats per cache line; power of two, ≥2

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- re_i  in  1  I-side burst request; held high for the whole burst
- addr_i  in  ADDR_W  I-side line base word address; sampled at grant
- valid_i  out  1  I-side beat strobe; rdata valid this cycle
- re_d  in  1  D-side burst request
- addr_d  in  ADDR_W  D-side line base word address
- valid_d  out  1  D-side beat strobe
- rdata  out  DATA_W  combinational copy of mm_rdata, shared by both sides
- mm_re  out  1  main-memory read enable
- mm_addr  out  ADDR_W  main-memory word address
- mm_rdata  in  DATA_W  main-memory read data
- mm_valid  in  1  main-memory beat valid
- mm_reset  out  1  one-cycle burst-restart pulse to main memory
- busy  out  1  a grant is in progress (START, BURST or DONE)
- owner  out  1  current or most recent grantee: 0 = I, 1 = D

## Operation
- States: IDLE, START, BURST, DONE.
- Internal registers:
  - `base` (ADDR_W)
  - `beat` ($clog2(LINE_WORDS) bits)
  - `last` (1 bit): last served side
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of re_i/re_d high: grant that side.
  - Both high: grant the side ≠ `last`.
  - On grant: latch owner and `base` from the owner's addr, clear `beat`, go to START.
- START:
  - mm_reset = 1, mm_re = 0.
  - Go to BURST.
- BURST:
  - mm_re = 1; mm_addr = `base` + `beat` (zero-extended, modulo 2^ADDR_W).
  - On mm_valid: pulse the owner's valid_x for that cycle and increment `beat`.
  - If `beat` == LINE_WORDS-1 while mm_valid = 1: go to DONE.
- DONE:
  - mm_re = 0, mm_reset = 1 (end-of-burst restart).
  - `last` ← owner; go to IDLE.
- Abort: if the owner's re_x drops in BURST, no valid_x is issued that cycle, even if mm_valid = 1. Go to DONE and clear `beat`.
- The non-owner's request is ignored until IDLE; it never sees valid_x.
- mm_valid outside BURST is ignored; no valid_x is generated.
- mm_addr outside BURST holds `base`; mm_re is high only in BURST.
- Reset values:
  - All outputs 0, including mm_addr = 0, owner = 0, busy = 0.
  - State IDLE, `beat` = 0, `last` = 1, so I wins the first tie.
- Reset asserted mid-burst: all outputs drop to reset values asynchronously, with no DONE cycle. The burst restarts from beat 0 after a new grant.

## Timing
- Request seen in IDLE at edge n:
  - START during cycle n+1: mm_reset = 1, busy = 1, owner valid.
  - BURST from cycle n+2: first mm_re = 1.
- valid_x is combinational from mm_valid in BURST: zero-cycle beat latency, rdata valid in the same cycle.
- Last beat accepted in cycle k: DONE in k+1, IDLE in k+2.
- Earliest next grant: START in k+3.
- Minimum burst occupancy with mm_valid always high: LINE_WORDS + 2 busy cycles.
- Requesters must hold re_x and addr_x stable until their final valid_x. addr_x is only sampled at the grant edge.

## Test plan
- Single I burst: re_i = 1, addr_i = 0x100, mm_valid always 1, LINE_WORDS = 4.
  - Expect mm_reset for 1 cycle, then mm_addr 0x100..0x103 with valid_i on 4 consecutive cycles.
  - Then DONE with mm_reset = 1, busy falling after 6 cycles; valid_d never high.
- Tie after reset: re_i and re_d high together from reset release.
  - Expect I served first (owner = 0), then D (owner = 1) with START 3 cycles after I's last beat.
  - Then I again if both are still requesting.
- Stalled memory: mm_valid pattern 1,0,0,1,0,1,1 during a D burst at addr_d = 0x3FE.
  - Expect exactly 4 valid_d pulses, aligned with the mm_valid highs.
  - Expect mm_addr advancing 0x3FE→0x3FF→0x400→0x401 only on accepted beats.
- Abort: re_d drops after the 2nd beat.
  - Expect the next cycle DONE (mm_re = 0), then IDLE; no further valid_d.
  - A subsequent D request restarts at its base address.
- Stray valid: mm_valid = 1 in IDLE and START.
  - Expect no valid_i/valid_d and no change to `beat`.
- Async reset mid-burst: reset = 0 between clock edges after the 2nd beat.
  - Expect mm_re, busy, valid_x and mm_addr to go to 0 immediately.
  - After release with re_i = 1: a fresh START and mm_addr starting at base.
